command_scheduler: RTL and testbench
====================================

COMMAND_SCHEDULER -- requirements
Module: command_scheduler

Interface
REQ-001 T_RCD, 3, cycles from activate strobe to mem_read/mem_write strobe, legal range 1..15.
REQ-002 T_RP, 3, cycles from precharge strobe to activate/refresh strobe, legal range 1..15.
REQ-003 T_RFC, 8, cycles from refresh strobe to earliest next strobe, legal range 1..255.
REQ-004 REF_INTERVAL, 1024, refresh period in cycles, minimum T_RFC+T_RP+T_RCD+8.
REQ-005 sys_clk  in  1  sole clock, rising edge.
REQ-006 sys_rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  2  per-requester request pending.
REQ-008 req_we  in  2  per-requester, 1=write, 0=read.
REQ-009 req_addr  in  64  requester i address at bits [32i+31:32i].
REQ-010 req_ready  out  2  one-cycle accept pulse per requester.
REQ-011 mem_read, mem_write, activate, precharge, refresh  out  1 each  one-hot command strobes to the command decoder.
REQ-012 addr  out  32  address accompanying any strobe, else 0.
REQ-013 busy  out  1  high when state != IDLE or refresh pending.

Function
REQ-014 All outputs SHALL be registered; at most one strobe high per cycle; each strobe lasts exactly one cycle.
REQ-015 Row SHALL be addr[31:12]; state holds open_row[19:0] and row_open flag.
REQ-016 Handshake: requester holds valid/we/addr stable until req_ready; req_ready[i] SHALL pulse in the same cycle as that request's mem_read/mem_write strobe.
REQ-017 Arbitration at IDLE SHALL be round-robin: with both valid, grant the requester not last granted; pointer updates only on req_ready; winner's we/addr latched at the IDLE decision.
REQ-018 FSM states: IDLE, ACTIVATE, WAIT_RCD, ACCESS, PRECHARGE, WAIT_RP, REFRESH, WAIT_RFC.
REQ-019 IDLE: ref_pending -> PRECHARGE if row_open else REFRESH; else valid row hit -> ACCESS; valid row miss with row_open -> PRECHARGE; valid with no open row -> ACTIVATE; else stay.
REQ-020 ACTIVATE/PRECHARGE/REFRESH/ACCESS SHALL each last one cycle and emit their strobe in that cycle.
REQ-021 Timing: activate-to-access exactly T_RCD cycles; precharge-to-next exactly T_RP; refresh-to-next at least T_RFC.
REQ-022 WAIT_RP exits to REFRESH if ref_pending else ACTIVATE; WAIT_RCD -> ACCESS; ACCESS, WAIT_RFC -> IDLE.
REQ-023 Latency from valid seen in IDLE at cycle N: hit -> access N+1; closed -> activate N+1, access N+1+T_RCD; conflict -> precharge N+1, activate N+1+T_RP, access N+1+T_RP+T_RCD.
REQ-024 Activate SHALL set row_open and open_row; precharge and refresh SHALL clear row_open.
REQ-025 Refresh counter counts down from REF_INTERVAL-1, sets ref_pending at 0 and reloads; expiry while pending SHALL NOT accumulate; refresh strobe clears ref_pending.
REQ-026 Refresh pending and request valid simultaneously at IDLE: refresh first; in-flight access sequences are never aborted by refresh.

Reset
REQ-027 On sys_rst: state IDLE, all strobes/req_ready/addr 0, row_open 0, ref_pending 0, counter REF_INTERVAL-1, round-robin pointer = requester 1 (requester 0 wins first tie).
REQ-028 Reset mid-sequence SHALL abort without emitting the pending strobe; first cycle after release all outputs 0.

Structure
REQ-029 Package command_scheduler_pkg SHALL hold the state encoding, ROW_LSB=12, and command codes matching the decoder (read 1, write 2, activate 3, precharge 4, refresh 5).
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter2; remaining logic flat.

Verification (T_RCD=3, T_RP=3, T_RFC=8, REF_INTERVAL=64)
REQ-031 Req0 read 0x0000_1000 after reset at cycle 10 -> activate@11 addr 0x1000, mem_read+req_ready[0]@14.
REQ-032 Then req0 write 0x0000_1FF0 (hit) valid@20 -> mem_write@21, no activate.
REQ-033 Then req1 read 0x0000_5000 (conflict) valid@30 -> precharge@31, activate@34, mem_read+req_ready[1]@37.
REQ-034 Both valid, rows closed, continuous traffic -> grants alternate 0,1,0,1; never two strobes in a cycle.
REQ-035 Counter expiry with row open and req valid -> precharge, refresh T_RP later, no strobe for T_RFC cycles, then activate for request.
REQ-036 sys_rst asserted in WAIT_RCD -> no mem_read issued, all outputs 0, busy 0 next cycle.

Source files
------------

// File: rtl/command_scheduler_pkg.sv
// Shared types for the command scheduler: FSM states, command codes
// and the row-extraction helper used for hit/miss decisions.
package command_scheduler_pkg;

  localparam int ROW_LSB = 12;
  localparam int ROW_W   = 32 - ROW_LSB;

  typedef enum logic [2:0] {
    IDLE,
    ACTIVATE,
    WAIT_RCD,
    ACCESS,
    PRECHARGE,
    WAIT_RP,
    REFRESH,
    WAIT_RFC
  } state_t;

  // Codes shared with the downstream command decoder.
  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_READ      = 3'd1,
    CMD_WRITE     = 3'd2,
    CMD_ACTIVATE  = 3'd3,
    CMD_PRECHARGE = 3'd4,
    CMD_REFRESH   = 3'd5
  } cmd_t;

  function automatic logic [ROW_W-1:0] row_of(
    input logic [31:0] a
  );
    return a[31:ROW_LSB];
  endfunction

endpackage

// File: rtl/command_scheduler_rr.sv
// Two-requester round-robin arbiter with its own last-grant pointer.
// Ports: req in, ack/ack_idx update the pointer, gnt_valid/gnt_idx out.
module rr_arbiter2 (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [1:0] req,
  input  logic       ack,
  input  logic       ack_idx,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last_q;

  // Reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      last_q <= 1'b1;
    end else if (ack) begin
      last_q <= ack_idx;
    end
  end

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    unique case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_q;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/command_scheduler.sv
// Memory command scheduler: arbitrates two requesters, tracks one open
// row, enforces tRCD/tRP/tRFC, and inserts periodic refresh.
// Ports: sys_clk/sys_rst; req_valid/req_we/req_addr in, req_ready out;
// mem_read/mem_write/activate/precharge/refresh strobes, addr, busy out.
module command_scheduler #(
  parameter int T_RCD        = 3,
  parameter int T_RP         = 3,
  parameter int T_RFC        = 8,
  parameter int REF_INTERVAL = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [63:0] req_addr,
  output logic [1:0]  req_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        activate,
  output logic        precharge,
  output logic        refresh,
  output logic [31:0] addr,
  output logic        busy
);

  import command_scheduler_pkg::*;

  localparam int CW = $clog2(REF_INTERVAL);
  localparam logic [CW-1:0] REF_LOAD = CW'(REF_INTERVAL - 1);

  // A wait state with load L lasts L+1 cycles, so the strobe that
  // follows lands exactly T cycles after the one that started it.
  localparam logic [7:0] RCD_LOAD = 8'((T_RCD > 1) ? T_RCD - 2 : 0);
  localparam logic [7:0] RP_LOAD  = 8'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [7:0] RFC_LOAD = 8'((T_RFC > 1) ? T_RFC - 2 : 0);

  state_t            state_q;
  state_t            state_n;
  state_t            rp_exit;
  logic [7:0]        timer_q;
  logic [7:0]        timer_load;
  logic              timer_done;
  logic [CW-1:0]     ref_cnt_q;
  logic              ref_pending_q;
  logic              ref_pending_n;
  logic              row_open_q;
  logic [ROW_W-1:0]  open_row_q;
  logic              lat_we;
  logic              lat_idx;
  logic [31:0]       lat_addr;
  logic              take;
  logic              gnt_valid;
  logic              gnt_idx;
  logic              win_we;
  logic [31:0]       win_addr;
  logic              row_hit;
  logic              cmd_we;
  logic              cmd_idx;
  logic [31:0]       cmd_addr;
  logic [31:0]       addr_n;
  cmd_t              cmd_n;

  rr_arbiter2 u_arb (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req       (req_valid),
    .ack       (state_q == ACCESS),
    .ack_idx   (lat_idx),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign win_we   = req_we[gnt_idx];
  assign win_addr = gnt_idx ? req_addr[63:32]
                            : req_addr[31:0];
  assign row_hit  = row_open_q &&
                    (open_row_q == row_of(win_addr));

  assign timer_done = (timer_q == 8'd0);
  assign rp_exit    = ref_pending_q ? REFRESH : ACTIVATE;

  always_comb begin
    state_n = state_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ref_pending_q) begin
          state_n = row_open_q ? PRECHARGE : REFRESH;
        end else if (gnt_valid) begin
          take    = 1'b1;
          state_n = row_hit    ? ACCESS    :
                    row_open_q ? PRECHARGE : ACTIVATE;
        end
      end
      ACTIVATE:
        state_n = (T_RCD > 1) ? WAIT_RCD : ACCESS;
      WAIT_RCD:
        if (timer_done) state_n = ACCESS;
      ACCESS:
        state_n = IDLE;
      PRECHARGE:
        state_n = (T_RP > 1) ? WAIT_RP : rp_exit;
      WAIT_RP:
        if (timer_done) state_n = rp_exit;
      REFRESH:
        state_n = (T_RFC > 1) ? WAIT_RFC : IDLE;
      WAIT_RFC:
        if (timer_done) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  // The request being served: straight from the winner on the IDLE
  // decision, from the latch afterwards.
  assign cmd_we   = take ? win_we   : lat_we;
  assign cmd_idx  = take ? gnt_idx  : lat_idx;
  assign cmd_addr = take ? win_addr : lat_addr;

  always_comb begin
    timer_load = 8'd0;
    unique case (state_n)
      WAIT_RCD: timer_load = RCD_LOAD;
      WAIT_RP:  timer_load = RP_LOAD;
      WAIT_RFC: timer_load = RFC_LOAD;
      default:  timer_load = 8'd0;
    endcase
  end

  always_comb begin
    cmd_n  = CMD_NONE;
    addr_n = 32'd0;
    unique case (state_n)
      ACTIVATE: begin
        cmd_n  = CMD_ACTIVATE;
        addr_n = cmd_addr;
      end
      ACCESS: begin
        cmd_n  = cmd_we ? CMD_WRITE : CMD_READ;
        addr_n = cmd_addr;
      end
      PRECHARGE: begin
        cmd_n  = CMD_PRECHARGE;
        addr_n = {open_row_q, {ROW_LSB{1'b0}}};
      end
      REFRESH:
        cmd_n = CMD_REFRESH;
      default: begin
        cmd_n  = CMD_NONE;
        addr_n = 32'd0;
      end
    endcase
  end

  // Expiry wins over the clear, so a pending refresh is never lost.
  always_comb begin
    ref_pending_n = ref_pending_q;
    if (ref_cnt_q == '0) begin
      ref_pending_n = 1'b1;
    end else if (state_q == REFRESH) begin
      ref_pending_n = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      timer_q       <= 8'd0;
      ref_cnt_q     <= REF_LOAD;
      ref_pending_q <= 1'b0;
      row_open_q    <= 1'b0;
      open_row_q    <= '0;
      lat_we        <= 1'b0;
      lat_idx       <= 1'b0;
      lat_addr      <= 32'd0;
      req_ready     <= 2'b00;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      activate      <= 1'b0;
      precharge     <= 1'b0;
      refresh       <= 1'b0;
      addr          <= 32'd0;
      busy          <= 1'b0;
    end else begin
      state_q <= state_n;

      if (state_n != state_q) begin
        timer_q <= timer_load;
      end else if (!timer_done) begin
        timer_q <= timer_q - 8'd1;
      end

      if (ref_cnt_q == '0) begin
        ref_cnt_q <= REF_LOAD;
      end else begin
        ref_cnt_q <= ref_cnt_q - 1'b1;
      end
      ref_pending_q <= ref_pending_n;

      if (state_n == ACTIVATE) begin
        row_open_q <= 1'b1;
        open_row_q <= row_of(cmd_addr);
      end else if (state_n == PRECHARGE ||
                   state_n == REFRESH) begin
        row_open_q <= 1'b0;
      end

      if (take) begin
        lat_we   <= win_we;
        lat_idx  <= gnt_idx;
        lat_addr <= win_addr;
      end

      req_ready <= (state_n != ACCESS) ? 2'b00 :
                   cmd_idx ? 2'b10 : 2'b01;
      mem_read  <= (cmd_n == CMD_READ);
      mem_write <= (cmd_n == CMD_WRITE);
      activate  <= (cmd_n == CMD_ACTIVATE);
      precharge <= (cmd_n == CMD_PRECHARGE);
      refresh   <= (cmd_n == CMD_REFRESH);
      addr      <= addr_n;
      busy      <= (state_n != IDLE) || ref_pending_n;
    end
  end

endmodule

// File: tb/tb_command_scheduler.sv
// Directed bench for command_scheduler with short timings and a
// 64-cycle refresh interval; each scenario checks cycle-exact strobes.
module tb_command_scheduler;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_we = 2'b00;
  logic [63:0] req_addr = 64'd0;
  logic [1:0]  req_ready;
  logic        mem_read;
  logic        mem_write;
  logic        activate;
  logic        precharge;
  logic        refresh;
  logic [31:0] addr;
  logic        busy;

  int cyc = 0;
  int base = 0;
  int checks = 0;
  int errors = 0;

  localparam logic [4:0] S_RD  = 5'b00001;
  localparam logic [4:0] S_WR  = 5'b00010;
  localparam logic [4:0] S_ACT = 5'b00100;
  localparam logic [4:0] S_PRE = 5'b01000;
  localparam logic [4:0] S_REF = 5'b10000;

  wire [4:0] strb = {refresh, precharge, activate,
                     mem_write, mem_read};

  command_scheduler #(
    .T_RCD        (3),
    .T_RP         (3),
    .T_RFC        (8),
    .REF_INTERVAL (64)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .activate  (activate),
    .precharge (precharge),
    .refresh   (refresh),
    .addr      (addr),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic at(input int n);
    while (cyc - base < n) @(negedge sys_clk);
  endtask

  // Leaves the bench at the negedge of relative cycle 0, which follows
  // the last clock edge that sampled reset.
  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst   = 1'b1;
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = 64'd0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    base    = cyc;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c <= 2; c++) begin
      at(c);
      checks++;
      if ({strb, req_ready, addr, busy} !== 40'd0) begin
        errors++;
        $display("FAIL reset c=%0d strb=%b rdy=%b addr=%h busy=%b exp all 0",
                 c, strb, req_ready, addr, busy);
      end
    end
  endtask

  task automatic test_closed();
    logic [4:0]  es;
    logic [1:0]  er;
    logic [31:0] ea;
    at(10);
    req_valid = 2'b01;
    req_we    = 2'b00;
    req_addr  = 64'h0000_0000_0000_1000;
    for (int c = 11; c <= 15; c++) begin
      at(c);
      es = 5'd0; er = 2'd0; ea = 32'd0;
      if (c == 11) begin es = S_ACT; ea = 32'h1000; end
      if (c == 14) begin
        es = S_RD; er = 2'b01; ea = 32'h1000;
      end
      checks++;
      if ({strb, req_ready, addr} !== {es, er, ea}) begin
        errors++;
        $display("FAIL closed c=%0d got %b/%b/%h exp %b/%b/%h",
                 c, strb, req_ready, addr, es, er, ea);
      end
      if (c == 12) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL closed_busy got %b exp 1", busy);
        end
      end
      if (c == 14) req_valid = 2'b00;
    end
  endtask

  task automatic test_hit();
    logic [4:0]  es;
    logic [1:0]  er;
    logic [31:0] ea;
    at(20);
    req_valid = 2'b01;
    req_we    = 2'b01;
    req_addr  = 64'h0000_0000_0000_1FF0;
    for (int c = 21; c <= 23; c++) begin
      at(c);
      es = 5'd0; er = 2'd0; ea = 32'd0;
      if (c == 21) begin
        es = S_WR; er = 2'b01; ea = 32'h1FF0;
      end
      checks++;
      if ({strb, req_ready, addr} !== {es, er, ea}) begin
        errors++;
        $display("FAIL hit c=%0d got %b/%b/%h exp %b/%b/%h",
                 c, strb, req_ready, addr, es, er, ea);
      end
      if (c == 21) req_valid = 2'b00;
    end
  endtask

  task automatic test_conflict();
    logic [4:0]  es;
    logic [1:0]  er;
    logic [31:0] ea;
    at(30);
    req_valid = 2'b10;
    req_we    = 2'b00;
    req_addr  = {32'h0000_5000, 32'h0000_1FF0};
    for (int c = 31; c <= 38; c++) begin
      at(c);
      es = 5'd0; er = 2'd0; ea = 32'd0;
      if (c == 31) begin es = S_PRE; ea = 32'h1000; end
      if (c == 34) begin es = S_ACT; ea = 32'h5000; end
      if (c == 37) begin
        es = S_RD; er = 2'b10; ea = 32'h5000;
      end
      checks++;
      if ({strb, req_ready, addr} !== {es, er, ea}) begin
        errors++;
        $display("FAIL conflict c=%0d got %b/%b/%h exp %b/%b/%h",
                 c, strb, req_ready, addr, es, er, ea);
      end
      if (c == 37) req_valid = 2'b00;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] eg [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    int         ec [4] = '{4, 12, 20, 28};
    int         ng = 0;
    int         multi = 0;
    int         nstrb = 0;
    do_reset();
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = {32'h0000_2000, 32'h0000_1000};
    for (int c = 1; c <= 30; c++) begin
      at(c);
      if ($countones(strb) > 1) multi++;
      nstrb += $countones(strb);
      if (req_ready != 2'b00) begin
        checks++;
        if (ng > 3) begin
          errors++;
          $display("FAIL rr_extra c=%0d rdy=%b exp none", c, req_ready);
        end else if (req_ready !== eg[ng] || c != ec[ng]) begin
          errors++;
          $display("FAIL rr_grant%0d got %b@%0d exp %b@%0d",
                   ng, req_ready, c, eg[ng], ec[ng]);
        end
        ng++;
      end
      if (c == 28) req_valid = 2'b00;
    end
    checks++;
    if (ng != 4) begin
      errors++;
      $display("FAIL rr_count got %0d exp 4", ng);
    end
    checks++;
    if (multi != 0) begin
      errors++;
      $display("FAIL rr_onehot got %0d multi-strobe cycles exp 0", multi);
    end
    checks++;
    if (nstrb != 11) begin
      errors++;
      $display("FAIL rr_strobes got %0d exp 11", nstrb);
    end
  endtask

  task automatic test_refresh();
    logic [4:0]  es;
    logic [1:0]  er;
    logic [31:0] ea;
    do_reset();
    req_valid = 2'b01;
    req_we    = 2'b00;
    req_addr  = 64'h0000_0000_0000_1000;
    at(4);
    checks++;
    if (req_ready !== 2'b01 || mem_read !== 1'b1) begin
      errors++;
      $display("FAIL ref_open got rdy=%b rd=%b exp 01/1",
               req_ready, mem_read);
    end
    req_valid = 2'b00;
    at(63);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ref_busy63 got %b exp 0", busy);
    end
    at(64);
    checks++;
    if (busy !== 1'b1 || strb !== 5'd0) begin
      errors++;
      $display("FAIL ref_busy64 got busy=%b strb=%b exp 1/00000",
               busy, strb);
    end
    req_valid = 2'b10;
    req_we    = 2'b00;
    req_addr  = {32'h0000_3000, 32'h0000_1000};
    for (int c = 65; c <= 81; c++) begin
      at(c);
      es = 5'd0; er = 2'd0; ea = 32'd0;
      if (c == 65) begin es = S_PRE; ea = 32'h1000; end
      if (c == 68) es = S_REF;
      if (c == 77) begin es = S_ACT; ea = 32'h3000; end
      if (c == 80) begin
        es = S_RD; er = 2'b10; ea = 32'h3000;
      end
      checks++;
      if ({strb, req_ready, addr} !== {es, er, ea}) begin
        errors++;
        $display("FAIL refresh c=%0d got %b/%b/%h exp %b/%b/%h",
                 c, strb, req_ready, addr, es, er, ea);
      end
      if (c == 80) req_valid = 2'b00;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 2'b01;
    req_we    = 2'b00;
    req_addr  = 64'h0000_0000_0000_1000;
    at(1);
    checks++;
    if (activate !== 1'b1) begin
      errors++;
      $display("FAIL mid_act got %b exp 1", activate);
    end
    at(2);
    sys_rst = 1'b1;
    at(3);
    checks++;
    if ({strb, req_ready, addr, busy} !== 40'd0) begin
      errors++;
      $display("FAIL mid_rst strb=%b rdy=%b addr=%h busy=%b exp all 0",
               strb, req_ready, addr, busy);
    end
    sys_rst   = 1'b0;
    req_valid = 2'b00;
    for (int c = 4; c <= 7; c++) begin
      at(c);
      checks++;
      if ({strb, req_ready, addr, busy} !== 40'd0) begin
        errors++;
        $display("FAIL mid_after c=%0d strb=%b rdy=%b addr=%h busy=%b exp all 0",
                 c, strb, req_ready, addr, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_closed();
    test_hit();
    test_conflict();
    test_round_robin();
    test_refresh();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
